// File: rtl/ramb_loader_pkg.sv
// Shared defaults and FSM state encoding for the matrix loader.
// Imported by the loader top and its memory sub-module.
package ramb_loader_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned N_DEF     = 8;
    localparam int unsigned DEPTH_DEF = N_DEF * N_DEF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/ramb_loader_mem.sv
// DEPTH x WIDTH storage: one write port and two registered read-first read ports.
// Out-of-range read addresses return zero; the array itself is never reset.
module ramb_loader_mem
    import ramb_loader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = 8,
    parameter int unsigned MAW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [MAW-1:0]   i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_addr1,
    input  logic [AW-1:0]    i_addr2,
    output logic [WIDTH-1:0] o_data1,
    output logic [WIDTH-1:0] o_data2
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic             w_in_range1;
    logic             w_in_range2;

    assign w_in_range1 = (i_addr1 < AW'(DEPTH));
    assign w_in_range2 = (i_addr2 < AW'(DEPTH));

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking reads of r_mem see the pre-write value on a colliding edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data1 <= '0;
            r_data2 <= '0;
        end else begin
            r_data1 <= w_in_range1 ? r_mem[i_addr1[MAW-1:0]] : '0;
            r_data2 <= w_in_range2 ? r_mem[i_addr2[MAW-1:0]] : '0;
        end
    end

    assign o_data1 = r_data1;
    assign o_data2 = r_data2;

endmodule

// File: rtl/ramb_loader.sv
// Streams N*N row-major elements into a dual-read-port RAM, optionally
// transposing on the fly; FSM, element counter and address mapping live here.
module ramb_loader
    import ramb_loader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned N     = N_DEF,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             transpose,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    output logic [WIDTH-1:0] data_out_1,
    output logic [WIDTH-1:0] data_out_2,
    output logic             busy,
    output logic             done,
    output logic [6:0]       count
);

    localparam int unsigned DEPTH = N * N;
    localparam int unsigned MAW   = $clog2(DEPTH);
    localparam logic [6:0]  LAST  = 7'(DEPTH - 1);

    state_t           r_state;
    logic [6:0]       r_count;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_transpose;

    logic             w_we;
    logic [6:0]       w_row;
    logic [6:0]       w_col;
    logic [MAW-1:0]   w_waddr;

    assign w_we  = r_in_ready & in_valid;
    assign w_row = r_count / 7'(N);
    assign w_col = r_count % 7'(N);
    // Element k arrives at (row, col); transposed storage swaps the two.
    assign w_waddr = r_transpose ? MAW'(w_col * 7'(N) + w_row) : MAW'(r_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_transpose <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state     <= StLoad;
                        r_count     <= '0;
                        r_transpose <= transpose;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        r_count <= r_count + 7'd1;
                        if (r_count == LAST) begin
                            r_state    <= StDone;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;

    ramb_loader_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .MAW   (MAW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (in_data),
        .i_addr1 (addr1),
        .i_addr2 (addr2),
        .o_data1 (data_out_1),
        .o_data2 (data_out_2)
    );

endmodule

// File: tb/tb_ramb_loader.sv
// Self-checking bench for ramb_loader: directed sequences, a read-vector table
// and randomized loads checked against an array model of the matrix memory.
module tb_ramb_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       transpose = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [7:0] addr1 = '0;
    logic [7:0] addr2 = '0;
    logic [7:0] data_out_1;
    logic [7:0] data_out_2;
    logic       busy;
    logic       done;
    logic [6:0] count;

    int n_pass  = 0;
    int n_total = 0;

    int ref_mem [64];
    bit ref_vld [64];

    typedef struct {
        logic [7:0] a1;
        logic [7:0] a2;
        int         e1;
        int         e2;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    ramb_loader #(
        .WIDTH (8),
        .N     (8),
        .AW    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .transpose  (transpose),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .addr1      (addr1),
        .addr2      (addr2),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int map_addr(input int k, input bit tr);
        int r = k / 8;
        int c = k % 8;
        return tr ? (c * 8 + r) : (r * 8 + c);
    endfunction

    function automatic int model_rd(input int a, output bit ok);
        if (a >= 64) begin
            ok = 1'b1;
            return 0;
        end
        ok = ref_vld[a];
        return ref_mem[a];
    endfunction

    task automatic read_check(input int a1, input int a2, input string tag);
        bit ok1, ok2;
        int e1, e2;
        addr1 = 8'(a1);
        addr2 = 8'(a2);
        e1 = model_rd(a1, ok1);
        e2 = model_rd(a2, ok2);
        step();
        if (ok1) check($sformatf("%s port1 addr %0d", tag, a1), int'($signed(data_out_1)), e1);
        if (ok2) check($sformatf("%s port2 addr %0d", tag, a2), int'($signed(data_out_2)), e2);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) read_check(a, 63 - a, tag);
    endtask

    // mode: 0 data=k, 1 data=-k, 2 random; stall: 0 none, 1 every other cycle, 2 random
    task automatic do_load(input bit tr, input int mode, input int stall, input bit poke_start,
                           input bit rand_addr, input string tag);
        int k, cyc, rdy_cyc, cnt_err, rd_err;
        bit v, rdy, ok1, ok2;
        int e1, e2;
        logic signed [7:0] d;
        k = 0; cyc = 0; rdy_cyc = 0; cnt_err = 0; rd_err = 0;
        start = 1'b1;
        transpose = tr;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        transpose = ~tr;
        check({tag, " busy at start"}, int'(busy), 1);
        check({tag, " in_ready at start"}, int'(in_ready), 1);
        check({tag, " count cleared"}, int'(count), 0);
        while (k < 64 && cyc < 1000) begin
            case (stall)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            case (mode)
                0: d = 8'(k);
                1: d = 8'(-k);
                default: d = 8'($urandom);
            endcase
            in_valid = v;
            in_data = d;
            if (poke_start) start = 1'($urandom_range(0, 1));
            if (rand_addr) begin
                addr1 = 8'($urandom_range(0, 79));
                addr2 = 8'($urandom);
            end
            e1 = model_rd(int'(addr1), ok1);
            e2 = model_rd(int'(addr2), ok2);
            rdy = in_ready;
            if (rdy) rdy_cyc++;
            @(posedge clk);
            if (v && rdy) begin
                ref_mem[map_addr(k, tr)] = int'(d);
                ref_vld[map_addr(k, tr)] = 1'b1;
                k++;
            end
            #1;
            if (int'(count) != k) cnt_err++;
            if (ok1 && int'($signed(data_out_1)) != e1) rd_err++;
            if (ok2 && int'($signed(data_out_2)) != e2) rd_err++;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check({tag, " count tracking errors"}, cnt_err, 0);
        check({tag, " read-during-load errors"}, rd_err, 0);
        check({tag, " done"}, int'(done), 1);
        check({tag, " busy low"}, int'(busy), 0);
        check({tag, " in_ready low"}, int'(in_ready), 0);
        check({tag, " final count"}, int'(count), 64);
        if (stall == 0) check({tag, " in_ready cycles"}, rdy_cyc, 64);
    endtask

    initial begin
        int old3;
        tbl[0] = '{a1: 8'd0,   a2: 8'd63,  e1: 0,  e2: 63};
        tbl[1] = '{a1: 8'd9,   a2: 8'd9,   e1: 9,  e2: 9};
        tbl[2] = '{a1: 8'd64,  a2: 8'd200, e1: 0,  e2: 0};
        tbl[3] = '{a1: 8'd255, a2: 8'd1,   e1: 0,  e2: 1};
        tbl[4] = '{a1: 8'd17,  a2: 8'd42,  e1: 17, e2: 42};
        tbl[5] = '{a1: 8'd128, a2: 8'd63,  e1: 0,  e2: 63};
        for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset in_ready", int'(in_ready), 0);
        check("reset count", int'(count), 0);
        check("reset data_out_1", int'(data_out_1), 0);
        check("reset data_out_2", int'(data_out_2), 0);
        rst = 1'b0;
        step();
        check("idle in_ready", int'(in_ready), 0);

        // Row-major continuous load, data = k
        do_load(1'b0, 0, 0, 1'b0, 1'b0, "rowmajor");
        read_check(9, 9, "rowmajor");
        addr1 = 8'd9;
        step();
        check("rowmajor addr 9 literal", int'(data_out_1), 9);
        for (int i = 0; i < 6; i++) begin
            addr1 = tbl[i].a1;
            addr2 = tbl[i].a2;
            step();
            check($sformatf("table %0d port1", i), int'($signed(data_out_1)), tbl[i].e1);
            check($sformatf("table %0d port2", i), int'($signed(data_out_2)), tbl[i].e2);
        end
        repeat (5) step();
        check("done holds", int'(done), 1);
        sweep("rowmajor sweep");

        // Transposed load, data = k
        do_load(1'b1, 0, 0, 1'b0, 1'b0, "transpose");
        addr1 = 8'd1;
        addr2 = 8'd8;
        step();
        check("transpose addr 1", int'(data_out_1), 8);
        check("transpose addr 8", int'(data_out_2), 1);
        addr1 = 8'd63;
        addr2 = 8'd63;
        step();
        check("transpose addr 63 p1", int'(data_out_1), 63);
        check("transpose addr 63 p2", int'(data_out_2), 63);
        sweep("transpose sweep");

        // Stalled load, data = -k
        do_load(1'b0, 1, 1, 1'b0, 1'b0, "stalled");
        addr1 = 8'd5;
        step();
        check("stalled addr 5 raw", int'(data_out_1), 32'hFB);
        sweep("stalled sweep");

        // Read-first collision at address 3
        old3 = ref_mem[3];
        start = 1'b1;
        transpose = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1;
            in_data = 8'(100 + k);
            addr1 = 8'd3;
            @(posedge clk);
            ref_mem[k] = int'($signed(8'(100 + k)));
            #1;
            if (k == 3) check("read-first old value", int'($signed(data_out_1)), old3);
            if (k == 4) check("read-first new value", int'($signed(data_out_1)), 103);
        end
        in_valid = 1'b0;
        step();
        check("collision load done", int'(done), 1);

        // Random data/stalls, start poked during load, random and out-of-range reads
        do_load(1'b1, 2, 2, 1'b1, 1'b1, "random1");
        sweep("random1 sweep");

        // Abort after 20 transfers with an asynchronous reset
        start = 1'b1;
        transpose = 1'b1;
        addr1 = 8'd0;
        addr2 = 8'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data = 8'(50 + k);
            @(posedge clk);
            ref_mem[map_addr(k, 1'b1)] = 50 + k;
            #1;
        end
        in_valid = 1'b0;
        check("abort count before reset", int'(count), 20);
        check("abort data before reset", int'(data_out_1), 50);
        #2;
        rst = 1'b1;
        #1;
        check("async reset data_out_1", int'(data_out_1), 0);
        check("async reset data_out_2", int'(data_out_2), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset in_ready", int'(in_ready), 0);
        check("async reset count", int'(count), 0);
        check("async reset done", int'(done), 0);
        rst = 1'b0;
        // Stray valids in IDLE must not write
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (4) begin
            step();
            check("idle ignores valid", int'(count), 0);
        end
        in_valid = 1'b0;
        sweep("post-abort sweep");

        for (int i = 0; i < 2; i++) begin
            do_load(1'($urandom_range(0, 1)), 2, 2, 1'b1, 1'b1, $sformatf("random%0d", i + 2));
            sweep($sformatf("random%0d sweep", i + 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ramb_loader.md
RAMB_LOADER -- requirements
Module: ramb_loader

Interface
REQ-001 Parameter: WIDTH, 8, element width in bits (signed two's complement).
REQ-002 Parameter: N, 8, matrix dimension; DEPTH = N*N = 64 locations.
REQ-003 Parameter: AW, 8, read-address width.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: start  input  1  begin a load of DEPTH elements; sampled only in IDLE or DONE.
REQ-007 Port: transpose  input  1  store column-major when 1, row-major when 0; latched on accepted start.
REQ-008 Port: in_valid  input  1  in_data holds a valid element.
REQ-009 Port: in_ready  output  1  loader accepts an element this cycle.
REQ-010 Port: in_data  input  WIDTH  signed element, streamed in row-major order.
REQ-011 Port: addr1, addr2  input  AW each  read addresses for the two read ports.
REQ-012 Port: data_out_1, data_out_2  output  WIDTH each  signed registered read data.
REQ-013 Port: busy  output  1  high while in LOAD.
REQ-014 Port: done  output  1  high in DONE; memory holds a complete matrix.
REQ-015 Port: count  output  7  number of elements accepted in the current load (0..64).

Function
REQ-016 FSM states SHALL be IDLE, LOAD, DONE.
REQ-017 IDLE/DONE with start=1 SHALL go to LOAD next cycle, clear count, latch transpose.
REQ-018 LOAD SHALL assert in_ready=1; IDLE and DONE SHALL hold in_ready=0.
REQ-019 A transfer SHALL occur exactly on a rising edge with in_valid=1 and in_ready=1; in_data is written and count increments.
REQ-020 For the k-th transfer (k=0..63), r=k/N, c=k%N; write address SHALL be r*N+c if transpose=0, c*N+r if transpose=1.
REQ-021 The transfer with k=DEPTH-1 SHALL move the FSM to DONE next cycle, count=64, in_ready=0 that cycle.
REQ-022 in_valid=0 in LOAD SHALL stall with no write and no count change; no timeout.
REQ-023 start asserted during LOAD SHALL be ignored.
REQ-024 done SHALL stay high in DONE until an accepted start or reset.
REQ-025 Both read ports SHALL operate in every state, latency 1 cycle: data_out_x <= memory[addr_x].
REQ-026 Read and write same address same edge SHALL return old data (read-first).
REQ-027 Read address >= DEPTH SHALL return 0 on that port.
REQ-028 addr1 = addr2 SHALL return identical data on both ports.
REQ-029 No arithmetic on data; elements are stored bit-exact, sign preserved.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, count=0, in_ready=0, busy=0, done=0, data_out_1=0, data_out_2=0.
REQ-031 Reset mid-load SHALL abort the load; memory contents SHALL be left unmodified (not cleared).
REQ-032 Memory array SHALL have no reset and no initial file load.

Structure
REQ-033 Shared package SHALL hold WIDTH, N, DEPTH defaults and the state encoding (IDLE=0, LOAD=1, DONE=2).
REQ-034 One sub-module, ramb_loader_mem: DEPTH x WIDTH, one write port, two registered read ports; the FSM, counter and address mapping live in ramb_loader.

Verification
REQ-035 Reset then start, transpose=0, stream 0..63 continuously -> in_ready high 64 cycles, done=1, read addr 9 -> 9 next cycle.
REQ-036 Same stream, transpose=1 -> read addr1=1 gives 8, addr2=8 gives 1 next cycle; addr 63 gives 63.
REQ-037 Load with in_valid toggled every other cycle, data -k -> count advances only on handshakes, addr 5 reads -5 (0xFB).
REQ-038 rst pulse after 20 transfers -> outputs zero asynchronously, state IDLE; earlier 20 locations retain written values.
REQ-039 start asserted during LOAD and addr1=64, addr2=200 -> load unaffected, both outputs read 0.
REQ-040 Read addr 3 on the same edge that writes addr 3 -> old value returned, new value one cycle later.
